// File: rtl/demux4_pkg.sv
// Shared constants for the four-lane stream demultiplexer.
package demux4_pkg;
  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam int OCC_W     = $clog2(DEF_DEPTH + 1);
endpackage

// File: rtl/demux4_lane_fifo.sv
// Per-lane circular-buffer FIFO with occupancy counter; head is the
// registered storage entry at the read pointer.
module demux4_lane_fifo
  import demux4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] occ
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Qualify push/pop against the state before the edge, so a full lane refuses a push even while popping.
  always_comb begin
    full_s  = (occ_r == CNT_W'(DEPTH));
    empty_s = (occ_r == {CNT_W{1'b0}});
    push_s  = push && !full_s;
    pop_s   = pop && !empty_s;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign full  = full_s;
  assign valid = !empty_s;
  assign head  = mem_r[rd_ptr_r];
  assign occ   = occ_r;

endmodule

// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer: routes each input word to the lane FIFO
// named by in_sel; in_ready never depends on out_ready.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*CNT_W-1:0] occ
);

  logic [LANES-1:0] full_s;
  logic [LANES-1:0] push_s;
  logic             in_ready_s;

  // Input acceptance looks only at the selected lane's fullness.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !full_s[in_sel];
    end
  end

  // One-hot push to the selected lane on an input transfer.
  always_comb begin
    push_s = {LANES{1'b0}};
    if (in_valid && in_ready_s) begin
      push_s[in_sel] = 1'b1;
    end else begin
      push_s = {LANES{1'b0}};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux4_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s[k]),
      .push_data (in_data),
      .full      (full_s[k]),
      .pop       (out_ready[k]),
      .head      (out_data[k*WIDTH +: WIDTH]),
      .valid     (out_valid[k]),
      .occ       (occ[k*CNT_W +: CNT_W])
    );
  end

  assign in_ready = in_ready_s;

endmodule

// File: tb/tb_demux4_stream.sv
// Randomised and directed bench for demux4_stream with a queue-based lane model.
module tb_demux4_stream;
  localparam int W = 32;
  localparam int D = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0]  out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*CW-1:0] occ;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  bit fresh [4];
  logic [W-1:0] mq [4][$];

  demux4_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane %0d at %0t: got %h expected %h", name, lane, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT against the lane model, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic exp_rdy;
    logic acc;
    if (armed) begin
      exp_rdy = !rst && (mq[in_sel].size() < D);
      chk("in_ready", int'(in_sel), {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int k = 0; k < 4; k++) begin
        chk("out_valid", k, {31'd0, out_valid[k]}, {31'd0, (mq[k].size() > 0)});
        chk("occ", k, {30'd0, occ[k*CW +: CW]}, 32'(mq[k].size()));
        if (mq[k].size() > 0) chk("out_data", k, out_data[k*W +: W], mq[k][0]);
        else if (fresh[k]) chk("out_data_cleared", k, out_data[k*W +: W], 32'd0);
      end
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        fresh[k] = 1'b1;
      end
      armed = 1'b1;
    end else if (armed) begin
      acc = in_valid && (mq[in_sel].size() < D);
      for (int k = 0; k < 4; k++) begin
        if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      end
      if (acc) begin
        mq[in_sel].push_back(in_data);
        fresh[in_sel] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until the DUT takes it (bounded).
  task automatic send(input logic [1:0] sel, input logic [W-1:0] data);
    logic acc;
    int n;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout lane %0d: got no accept expected accept of %h", sel, data);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h5555_5555; out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    step();

    // routing
    send(2'd0, 32'hAAAA0000);
    send(2'd1, 32'hBBBB0000);
    send(2'd2, 32'hCCCC0000);
    send(2'd3, 32'hDDDD0000);
    step(); step();

    // backpressure on lane 1, lane 3 still flows
    out_ready = 4'b1101;
    send(2'd1, 32'h11110001);
    send(2'd1, 32'h11110002);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11110003;
    step(); step();
    in_valid = 1'b0;
    send(2'd3, 32'h3333_0001);
    out_ready = 4'hF;
    send(2'd1, 32'h11110003);
    step(); step();

    // simultaneous push/pop on lane 0
    out_ready = 4'b1110;
    send(2'd0, 32'h0000A001);
    out_ready = 4'hF;
    send(2'd0, 32'h0000CAFE);
    step(); step();

    // full lane 2 popped and pushed in the same cycle
    out_ready = 4'b1011;
    send(2'd2, 32'h2222_0001);
    send(2'd2, 32'h2222_0002);
    out_ready = 4'hF;
    send(2'd2, 32'h2222_0003);
    step(); step();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom);
      step();
    end
    in_valid = 1'b0;

    // reset with words queued and a handshake offered in the reset cycle
    out_ready = 4'h0;
    send(2'd0, 32'hDEAD_0000);
    send(2'd2, 32'hDEAD_0002);
    send(2'd2, 32'hDEAD_0003);
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hDEAD_0033;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    repeat (4) step();

    // drain
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/demux4_stream.md
# demux4_stream

Four-way stream demultiplexer, the distribution-side counterpart of the 32-bit 4:1 mux. Routes each 32-bit input word to one of four output lanes chosen by a 2-bit select carried with the word. Each lane has a 2-entry FIFO, so a stalled lane does not block words bound for other lanes once they are accepted. Sits between a single producer and four independent consumers, all on one clock domain.

## Interface
- WIDTH, 32, data word width
- DEPTH, 2, entries per lane FIFO (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination lane (0..3), qualified by in_valid
- in_valid  input  1  producer offers in_data/in_sel
- in_ready  output  1  selected lane can accept this cycle
- out_data  output  4*WIDTH  lane k data at bits [k*WIDTH +: WIDTH]
- out_valid  output  4  lane k head word valid
- out_ready  input  4  lane k consumer accepts head
- occ  output  4*$clog2(DEPTH+1)  per-lane occupancy, lane k at slice k

## Operation
- Transfer on input when in_valid && in_ready; word pushed into lane in_sel FIFO only.
- in_ready = !rst && !full[in_sel]; depends on in_sel and lane state only, never on out_ready (no combinational path from out_ready to in_ready).
- Lane k pop when out_valid[k] && out_ready[k]; out_valid[k] = (occ_k != 0); out_data slice = FIFO head.
- Per-lane FIFO: circular buffer, wr/rd pointers wrap at DEPTH, occupancy counter 0..DEPTH.
- Push and pop same lane same cycle: both occur if not full before the edge; occ unchanged; order preserved. If full, push refused (in_ready low) even though a pop occurs that cycle.
- Pop on empty impossible (out_valid low); out_ready with out_valid low ignored.
- Lanes independent: a full lane 2 blocks only words with in_sel=2; in_sel=0 words still accepted.
- in_sel sampled only with in_valid high; no state retained between transfers except FIFO contents.
- Strict per-lane FIFO order; no ordering guarantee across lanes.

## Timing
- Reset (rst high at edge): all pointers and occ = 0, out_valid = 4'b0000, out_data = 0 (storage cleared), in_ready = 0 while rst high. Words in FIFOs at reset are discarded; handshake in the reset cycle is ignored.
- First cycle after rst low: in_ready = 1 for any in_sel.
- Latency: word accepted at edge N appears on out_valid/out_data of its lane in cycle N+1 (one register stage). Throughput one word per cycle on input; each lane one word per cycle on output.
- occ updates at same edge as the push/pop causing it.
- out_data of a lane holds stable while out_valid high and out_ready low.

## Structure
- Shared package/header demux4_pkg: LANES = 4, SEL_W = 2, default WIDTH and DEPTH, OCC_W = $clog2(DEPTH+1).
- Sub-module demux4_lane_fifo (push, push_data, full, pop, head, valid, occ); top instantiates four via generate and holds the select decode and in_ready mux.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0000, occ=0, in_ready=0; after release in_ready=1.
- Routing: send AAAA0000/sel0, BBBB0000/sel1, CCCC0000/sel2, DDDD0000/sel3, all out_ready=1 → each appears on its lane exactly one cycle after acceptance, other lanes valid=0.
- Backpressure: out_ready[1]=0, send 11110001, 11110002, 11110003 to lane 1 → first two accepted (occ1=2), in_ready=0 for third; meanwhile a sel3 word is accepted; release out_ready[1] → 11110001 then 11110002 in order, then third accepted.
- Simultaneous push/pop: lane 0 occ=1, out_ready[0]=1 and push 0000CAFE same cycle → occ0 stays 1, head becomes 0000CAFE next cycle.
- Full-lane pop+push: lane 2 occ=2, out_ready[2]=1, in_sel=2 → in_ready=0 that cycle, occ2=1 after edge, push accepted the following cycle.
- Reset mid-operation: lanes holding words, assert rst one cycle → all occ=0, out_valid=0000, previous words never emitted.
